// File: rtl/uart_rx_pkt_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_pkt_ctrl
//
// Frames the byte stream coming out of a UART receiver into validated
// packets of the form  SYNC_BYTE, LEN, LEN payload bytes, CHK  where CHK is
// the XOR of LEN and every payload byte. A good packet is held in a small
// payload buffer until the consumer acknowledges it; bad or stalled frames
// are dropped and reported with one-cycle error pulses.
//
// Parameters
//   TIMEOUT_CLKS : max idle clocks between bytes inside a frame (<= 65535)
//   MAX_LEN      : max payload bytes per frame (1..16)
//   SYNC_BYTE    : frame start marker
//
// Ports
//   i_Clock       : sole clock, everything on the rising edge
//   i_Reset       : synchronous active-high reset
//   i_RX_DV       : one-cycle strobe, i_RX_Byte is valid
//   i_RX_Byte     : received byte
//   i_Pkt_Ack     : consumer releases the held packet
//   i_Rd_Addr     : payload buffer read index
//   o_Rd_Data     : payload byte at i_Rd_Addr (combinational read)
//   o_Pkt_Valid   : a validated packet is held in the buffer
//   o_Pkt_Len     : payload length of the held packet
//   o_Busy        : controller is anywhere but IDLE
//   o_Err_Chk     : checksum mismatch pulse
//   o_Err_Len     : illegal length byte pulse
//   o_Err_Timeout : inter-byte timeout pulse
//   o_Overrun     : byte arrived while a packet was held pulse
// ---------------------------------------------------------------------------
module uart_rx_pkt_ctrl #(
  parameter int         TIMEOUT_CLKS = 21700,
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  input  logic       i_Pkt_Ack,
  input  logic [3:0] i_Rd_Addr,
  output logic [7:0] o_Rd_Data,
  output logic       o_Pkt_Valid,
  output logic [4:0] o_Pkt_Len,
  output logic       o_Busy,
  output logic       o_Err_Chk,
  output logic       o_Err_Len,
  output logic       o_Err_Timeout,
  output logic       o_Overrun
);

  typedef enum logic [2:0] {
    IDLE,
    GET_LEN,
    GET_DATA,
    GET_CHK,
    HOLD
  } state_t;

  localparam logic [7:0]  LP_MAX_LEN  = 8'(MAX_LEN);
  localparam logic [15:0] LP_TMO_LAST = 16'(TIMEOUT_CLKS - 1);

  state_t      r_State;
  logic [4:0]  r_Idx;
  logic [4:0]  r_Len;
  logic [7:0]  r_Xor;
  logic [15:0] r_Tmo;
  logic        r_Pkt_Valid;
  logic [4:0]  r_Pkt_Len;
  logic        r_Err_Chk;
  logic        r_Err_Len;
  logic        r_Err_Timeout;
  logic        r_Overrun;
  logic [7:0]  r_Buf [0:MAX_LEN-1];

  logic w_In_Get;
  logic w_Tmo_Hit;
  logic w_Len_Ok;
  logic w_Last_Data;
  logic w_Buf_We;

  assign w_In_Get    = (r_State == GET_LEN) || (r_State == GET_DATA) ||
                       (r_State == GET_CHK);
  // A byte arriving in the expiry cycle wins over the timeout.
  assign w_Tmo_Hit   = w_In_Get && !i_RX_DV && (r_Tmo == LP_TMO_LAST);
  assign w_Len_Ok    = (i_RX_Byte != 8'd0) && (i_RX_Byte <= LP_MAX_LEN);
  assign w_Last_Data = (r_Idx == (r_Len - 5'd1));
  assign w_Buf_We    = !i_Reset && (r_State == GET_DATA) && i_RX_DV;

  // Frame parser. Error pulses default low every cycle so each one is
  // exactly one clock wide; a frame ends on its first error so it can
  // raise at most one.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_State       <= IDLE;
      r_Idx         <= '0;
      r_Len         <= '0;
      r_Xor         <= '0;
      r_Tmo         <= '0;
      r_Pkt_Valid   <= 1'b0;
      r_Pkt_Len     <= '0;
      r_Err_Chk     <= 1'b0;
      r_Err_Len     <= 1'b0;
      r_Err_Timeout <= 1'b0;
      r_Overrun     <= 1'b0;
    end else begin
      r_Err_Chk     <= 1'b0;
      r_Err_Len     <= 1'b0;
      r_Err_Timeout <= 1'b0;
      r_Overrun     <= 1'b0;

      // Inter-byte watchdog only runs while collecting a frame.
      if (w_In_Get) begin
        if (i_RX_DV || w_Tmo_Hit) begin
          r_Tmo <= '0;
        end else begin
          r_Tmo <= r_Tmo + 16'd1;
        end
      end

      if (w_Tmo_Hit) begin
        r_Err_Timeout <= 1'b1;
        r_State       <= IDLE;
      end else begin
        case (r_State)
          IDLE: begin
            if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) begin
              r_State <= GET_LEN;
              r_Tmo   <= '0;
            end
          end

          GET_LEN: begin
            if (i_RX_DV) begin
              if (w_Len_Ok) begin
                r_Len   <= i_RX_Byte[4:0];
                r_Idx   <= '0;
                r_Xor   <= i_RX_Byte;
                r_State <= GET_DATA;
              end else begin
                r_Err_Len <= 1'b1;
                r_State   <= IDLE;
              end
            end
          end

          GET_DATA: begin
            if (i_RX_DV) begin
              r_Xor <= r_Xor ^ i_RX_Byte;
              r_Idx <= r_Idx + 5'd1;
              if (w_Last_Data) begin
                r_State <= GET_CHK;
              end
            end
          end

          GET_CHK: begin
            if (i_RX_DV) begin
              if (i_RX_Byte == r_Xor) begin
                r_Pkt_Valid <= 1'b1;
                r_Pkt_Len   <= r_Len;
                r_State     <= HOLD;
              end else begin
                r_Err_Chk <= 1'b1;
                r_State   <= IDLE;
              end
            end
          end

          HOLD: begin
            // Anything received while holding is lost, even a SYNC byte
            // that lands in the same cycle as the acknowledge.
            if (i_RX_DV) begin
              r_Overrun <= 1'b1;
            end
            if (i_Pkt_Ack) begin
              r_Pkt_Valid <= 1'b0;
              r_Pkt_Len   <= '0;
              r_State     <= IDLE;
            end
          end

          default: begin
            r_State <= IDLE;
          end
        endcase
      end
    end
  end

  // Payload storage has no reset; only GET_DATA writes it, so it stays
  // frozen while a packet is held.
  always_ff @(posedge i_Clock) begin
    if (w_Buf_We) begin
      r_Buf[r_Idx[3:0]] <= i_RX_Byte;
    end
  end

  always_comb begin
    o_Rd_Data = '0;
    if (32'(i_Rd_Addr) < MAX_LEN) begin
      o_Rd_Data = r_Buf[i_Rd_Addr];
    end
  end

  assign o_Pkt_Valid   = r_Pkt_Valid;
  assign o_Pkt_Len     = r_Pkt_Len;
  assign o_Busy        = (r_State != IDLE);
  assign o_Err_Chk     = r_Err_Chk;
  assign o_Err_Len     = r_Err_Len;
  assign o_Err_Timeout = r_Err_Timeout;
  assign o_Overrun     = r_Overrun;

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_pkt_ctrl
//
// Drives uart_rx_pkt_ctrl with directed frames followed by randomized
// frames. Expected results come from the frame rules themselves: the bench
// builds each frame, computes its checksum with plain XOR, and predicts
// whether it is held or rejected and which error counter must move.
// ---------------------------------------------------------------------------
module tb_uart_rx_pkt_ctrl;

  localparam int TMO  = 40;
  localparam int MAXL = 16;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       clock;
  logic       reset;
  logic       rxDv;
  logic [7:0] rxByte;
  logic       pktAck;
  logic [3:0] rdAddr;
  logic [7:0] rdData;
  logic       pktValid;
  logic [4:0] pktLen;
  logic       busy;
  logic       errChk;
  logic       errLen;
  logic       errTmo;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  // Pulse-high cycle counters seen by the monitor, and what the bench
  // expects them to be.
  int cntChk = 0, cntLen = 0, cntTmo = 0, cntOvr = 0;
  int expChk = 0, expLen = 0, expTmo = 0, expOvr = 0;

  logic [7:0] txQ[$];
  logic [7:0] payload [0:15];

  uart_rx_pkt_ctrl #(
    .TIMEOUT_CLKS(TMO),
    .MAX_LEN(MAXL),
    .SYNC_BYTE(SYNC)
  ) dut (
    .i_Clock(clock),
    .i_Reset(reset),
    .i_RX_DV(rxDv),
    .i_RX_Byte(rxByte),
    .i_Pkt_Ack(pktAck),
    .i_Rd_Addr(rdAddr),
    .o_Rd_Data(rdData),
    .o_Pkt_Valid(pktValid),
    .o_Pkt_Len(pktLen),
    .o_Busy(busy),
    .o_Err_Chk(errChk),
    .o_Err_Len(errLen),
    .o_Err_Timeout(errTmo),
    .o_Overrun(overrun)
  );

  // 100 MHz free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count every cycle each pulse output is high, sampled mid-cycle, so a
  // pulse wider than one clock shows up as an extra count.
  always @(negedge clock) begin
    if (errChk)  cntChk <= cntChk + 1;
    if (errLen)  cntLen <= cntLen + 1;
    if (errTmo)  cntTmo <= cntTmo + 1;
    if (overrun) cntOvr <= cntOvr + 1;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present one byte with a single-cycle DV strobe.
  task automatic applyStimulus(input logic [7:0] b);
    rxDv   = 1'b1;
    rxByte = b;
    tick();
    rxDv   = 1'b0;
    rxByte = $urandom_range(0, 255);
  endtask

  task automatic sendQueue(input int maxGap);
    while (txQ.size() > 0) begin
      applyStimulus(txQ.pop_front());
      if (maxGap > 0 && txQ.size() > 0) idle($urandom_range(0, maxGap));
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Let any pulse from the last edge be counted, then compare all four.
  task automatic checkErrs(input string tag);
    idle(2);
    checkOutput({tag, ".errChk"}, cntChk, expChk);
    checkOutput({tag, ".errLen"}, cntLen, expLen);
    checkOutput({tag, ".errTmo"}, cntTmo, expTmo);
    checkOutput({tag, ".ovr"},    cntOvr, expOvr);
  endtask

  // Checksum rule: XOR of the length byte and every payload byte.
  function automatic logic [7:0] frameChk(input int len);
    logic [7:0] c;
    c = 8'(len);
    for (int i = 0; i < len; i++) c = c ^ payload[i];
    return c;
  endfunction

  task automatic queueFrame(input int len, input logic [7:0] chk);
    txQ.push_back(SYNC);
    txQ.push_back(8'(len));
    for (int i = 0; i < len; i++) txQ.push_back(payload[i]);
    txQ.push_back(chk);
  endtask

  task automatic checkHeld(input string tag, input int len);
    checkOutput({tag, ".valid"}, pktValid, 1);
    checkOutput({tag, ".len"}, pktLen, len);
    for (int i = 0; i < len; i++) begin
      rdAddr = 4'(i);
      #1;
      checkOutput({tag, ".data"}, rdData, payload[i]);
    end
  endtask

  task automatic ackPacket(input string tag);
    pktAck = 1'b1;
    tick();
    pktAck = 1'b0;
    checkOutput({tag, ".ackValid"}, pktValid, 0);
    checkOutput({tag, ".ackBusy"}, busy, 0);
    checkOutput({tag, ".ackLen"}, pktLen, 0);
  endtask

  // Directed scenarios first, then randomized frames.
  initial begin
    int kind;
    int len;
    logic [7:0] chk;
    logic [7:0] noise;

    reset  = 1'b1;
    rxDv   = 1'b0;
    rxByte = 8'h00;
    pktAck = 1'b0;
    rdAddr = 4'd0;

    // Reset with a SYNC strobe that must be ignored.
    tick();
    rxDv = 1'b1; rxByte = SYNC;
    tick();
    rxDv = 1'b0;
    reset = 1'b0;
    checkOutput("reset.valid", pktValid, 0);
    checkOutput("reset.len", pktLen, 0);
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.pulses", {errChk, errLen, errTmo, overrun}, 0);
    tick();
    checkOutput("reset.busyAfter", busy, 0);

    // Basic good frame of three bytes.
    payload[0] = 8'h11; payload[1] = 8'h22; payload[2] = 8'h33;
    queueFrame(3, frameChk(3));
    sendQueue(0);
    checkHeld("good3", 3);
    ackPacket("good3");
    checkErrs("good3");

    // Bad checksum, then a good frame is still accepted.
    txQ = '{SYNC, 8'h02, 8'hAA, 8'hBB, 8'hFF};
    sendQueue(0);
    checkOutput("badChk.pulse", errChk, 1);
    checkOutput("badChk.valid", pktValid, 0);
    checkOutput("badChk.busy", busy, 0);
    expChk++;
    checkErrs("badChk");
    payload[0] = 8'h42;
    queueFrame(1, frameChk(1));
    sendQueue(0);
    checkHeld("afterChk", 1);
    ackPacket("afterChk");

    // Zero and too-large length bytes.
    txQ = '{SYNC, 8'h00};
    sendQueue(0);
    checkOutput("len0.busy", busy, 0);
    expLen++;
    checkErrs("len0");
    txQ = '{SYNC, 8'h11};
    sendQueue(0);
    checkOutput("len17.busy", busy, 0);
    expLen++;
    checkErrs("len17");
    txQ = '{SYNC, 8'h10};
    sendQueue(0);
    checkOutput("len16.busy", busy, 1);
    checkErrs("len16");
    // Abandon that frame via reset: no pulse may come out of it.
    reset = 1'b1; tick(); reset = 1'b0;

    // Stall mid-frame: silent for TMO-1 clocks, then expiry on the next.
    txQ = '{SYNC, 8'h04, 8'h01};
    sendQueue(0);
    idle(TMO - 1);
    checkOutput("tmo.busyBefore", busy, 1);
    checkOutput("tmo.noPulseYet", cntTmo, expTmo);
    tick();
    checkOutput("tmo.pulse", errTmo, 1);
    checkOutput("tmo.busy", busy, 0);
    expTmo++;
    checkErrs("tmo");

    // Long gaps that stay just inside the limit, including a byte that
    // arrives in the very cycle the counter expires.
    payload[0] = 8'h01; payload[1] = 8'h02; payload[2] = 8'h03; payload[3] = 8'h04;
    applyStimulus(SYNC);
    idle(TMO - 2);
    applyStimulus(8'h04);
    idle(TMO - 1);
    applyStimulus(payload[0]);
    idle(TMO - 2);
    applyStimulus(payload[1]);
    idle(TMO - 2);
    applyStimulus(payload[2]);
    idle(TMO - 1);
    applyStimulus(payload[3]);
    idle(TMO - 2);
    applyStimulus(frameChk(4));
    checkHeld("slow4", 4);
    checkErrs("slow4");

    // Bytes arriving while held are dropped with an overrun pulse.
    applyStimulus(SYNC);
    checkOutput("ovr.pulse", overrun, 1);
    expOvr++;
    applyStimulus(8'h03);
    expOvr++;
    checkErrs("ovr");
    checkHeld("ovrHeld", 4);
    pktAck = 1'b1;
    applyStimulus(SYNC);
    pktAck = 1'b0;
    expOvr++;
    checkOutput("ovrAck.valid", pktValid, 0);
    checkOutput("ovrAck.busy", busy, 0);
    applyStimulus(8'h00);
    checkOutput("ovrAck.notFramed", busy, 0);
    checkErrs("ovrAck");

    // Acknowledge outside HOLD does nothing.
    pktAck = 1'b1; tick(); pktAck = 1'b0;
    applyStimulus(SYNC);
    pktAck = 1'b1; tick(); pktAck = 1'b0;
    checkOutput("ackIgnored.busy", busy, 1);
    payload[0] = 8'h5C;
    txQ = '{8'h01, 8'h5C, frameChk(1)};
    sendQueue(0);
    checkHeld("ackIgnored", 1);
    ackPacket("ackIgnored");

    // Reset in the middle of the payload.
    txQ = '{SYNC, 8'h05, 8'h01, 8'h02};
    sendQueue(0);
    reset = 1'b1; rxDv = 1'b1; rxByte = 8'h03;
    tick();
    reset = 1'b0; rxDv = 1'b0;
    checkOutput("rstMid.valid", pktValid, 0);
    checkOutput("rstMid.len", pktLen, 0);
    checkOutput("rstMid.busy", busy, 0);
    checkOutput("rstMid.pulses", {errChk, errLen, errTmo, overrun}, 0);
    idle(TMO + 5);
    checkErrs("rstMid");
    payload[0] = 8'h7E;
    queueFrame(1, frameChk(1));
    sendQueue(0);
    checkHeld("rstNext", 1);
    ackPacket("rstNext");

    // Randomized frames with noise, bad lengths and corrupted checksums.
    for (int f = 0; f < 24; f++) begin
      if ($urandom_range(0, 1) == 1) begin
        noise = 8'($urandom_range(0, 255));
        if (noise == SYNC) noise = 8'h5A;
        applyStimulus(noise);
      end
      kind = $urandom_range(0, 9);
      if (kind == 0 || kind == 1) begin
        len = (kind == 0) ? 0 : $urandom_range(MAXL + 1, 255);
        txQ = '{SYNC, 8'(len)};
        sendQueue(3);
        expLen++;
        checkOutput("rnd.badLenValid", pktValid, 0);
        checkErrs("rnd.badLen");
      end else begin
        len = $urandom_range(1, MAXL);
        for (int i = 0; i < len; i++) payload[i] = 8'($urandom_range(0, 255));
        chk = frameChk(len);
        if (kind <= 3) chk = chk ^ 8'($urandom_range(1, 255));
        queueFrame(len, chk);
        sendQueue(3);
        if (kind <= 3) begin
          expChk++;
          checkOutput("rnd.badChkValid", pktValid, 0);
          checkErrs("rnd.badChk");
        end else begin
          checkHeld("rnd.good", len);
          checkErrs("rnd.good");
          ackPacket("rnd.good");
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
